// File: rtl/pla_sweep_ctrl.sv
// Exhaustive 8-input sweep controller for a combinational function under test.
// Optional MISR signature over the sampled responses: define PLA_SWEEP_MISR_EN.
module pla_sweep_ctrl #(
  parameter int unsigned SETTLE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        y0,
  input  logic        exp_y,
  output logic [7:0]  x,
  output logic        busy,
  output logic        done,
  output logic [8:0]  onset_cnt,
  output logic [8:0]  mism_cnt,
  output logic [7:0]  first_mism,
  output logic        first_mism_vld,
  output logic [15:0] sig
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [3:0]  settle_q, settle_d;
  logic [8:0]  onset_q, onset_d;
  logic [8:0]  mism_q, mism_d;
  logic [7:0]  fm_q, fm_d;
  logic        fmv_q, fmv_d;
  logic        accept;
  logic        sample;
  logic        mism_now;

  // Abort wins over the sample that would otherwise happen on the same edge.
  assign accept   = (state_q == IDLE) && start;
  assign sample   = (state_q == SWEEP) && !abort && (settle_q == SETTLE_LAST);
  assign mism_now = y0 ^ exp_y;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    settle_d = settle_q;
    onset_d  = onset_q;
    mism_d   = mism_q;
    fm_d     = fm_q;
    fmv_d    = fmv_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SWEEP;
          x_d      = 8'h00;
          settle_d = 4'h0;
          onset_d  = 9'd0;
          mism_d   = 9'd0;
          fm_d     = 8'h00;
          fmv_d    = 1'b0;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sample) begin
          settle_d = 4'h0;
          x_d      = x_q + 8'd1;
          onset_d  = onset_q + {8'd0, y0};
          mism_d   = mism_q + {8'd0, mism_now};
          if (mism_now && !fmv_q) begin
            fm_d  = x_q;
            fmv_d = 1'b1;
          end
          if (x_q == 8'hFF) begin
            state_d = DONE;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= 8'h00;
      settle_q <= 4'h0;
      onset_q  <= 9'd0;
      mism_q   <= 9'd0;
      fm_q     <= 8'h00;
      fmv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      settle_q <= settle_d;
      onset_q  <= onset_d;
      mism_q   <= mism_d;
      fm_q     <= fm_d;
      fmv_q    <= fmv_d;
    end
  end

`ifdef PLA_SWEEP_MISR_EN
  logic [15:0] sig_q, sig_d;

  // CRC-16/CCITT style shift with the response bit folded into the feedback.
  always_comb begin
    sig_d = sig_q;
    if (accept) begin
      sig_d = 16'hFFFF;
    end else if (sample) begin
      sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ y0) ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 16'h0000;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`else
  assign sig = 16'h0000;
`endif

  assign x              = x_q;
  assign busy           = (state_q == SWEEP);
  assign done           = (state_q == DONE);
  assign onset_cnt      = onset_q;
  assign mism_cnt       = mism_q;
  assign first_mism     = fm_q;
  assign first_mism_vld = fmv_q;

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Directed bench for pla_sweep_ctrl: one instance with SETTLE=0, one with SETTLE=3.
module tb_pla_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, abort_a, y0_a, exp_a;
  logic        start_b, abort_b, y0_b, exp_b;
  logic [7:0]  x_a, x_b, fm_a, fm_b;
  logic        busy_a, busy_b, done_a, done_b, fmv_a, fmv_b;
  logic [8:0]  onset_a, onset_b, mism_a, mism_b;
  logic [15:0] sig_a, sig_b;
  int          mode_a, mode_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pla_sweep_ctrl #(.SETTLE(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .y0(y0_a), .exp_y(exp_a),
    .x(x_a), .busy(busy_a), .done(done_a), .onset_cnt(onset_a), .mism_cnt(mism_a),
    .first_mism(fm_a), .first_mism_vld(fmv_a), .sig(sig_a)
  );

  pla_sweep_ctrl #(.SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .y0(y0_b), .exp_y(exp_b),
    .x(x_b), .busy(busy_b), .done(done_b), .onset_cnt(onset_b), .mism_cnt(mism_b),
    .first_mism(fm_b), .first_mism_vld(fmv_b), .sig(sig_b)
  );

  // Stimulus modes: 0 -> y0=0,exp=0; 1 -> y0=x[0],exp=0; 2 -> y0=1,exp=0; 3 -> y0=1,exp=1
  function automatic logic f_y(input int mode, input logic [7:0] xv);
    case (mode)
      0:       return 1'b0;
      1:       return xv[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic f_exp(input int mode);
    return (mode == 3);
  endfunction

  always_comb begin
    y0_a  = f_y(mode_a, x_a);
    exp_a = f_exp(mode_a);
    y0_b  = f_y(mode_b, x_b);
    exp_b = f_exp(mode_b);
  end

  function automatic logic [15:0] misr_exp(input int mode);
    logic [15:0] s;
    logic        y;
    s = 16'h0000;
`ifdef PLA_SWEEP_MISR_EN
    s = 16'hFFFF;
    for (int v = 0; v < 256; v++) begin
      y = f_y(mode, 8'(v));
      s = {s[14:0], 1'b0} ^ ((s[15] ^ y) ? 16'h1021 : 16'h0000);
    end
`endif
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
    $display("check %-16s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Pulses start on the selected instance and runs until done or budget; n counts
  // cycles after the start edge (first post-edge cycle is 1).
  task automatic run_sweep(input bit sel, input int budget, input int mid_start,
                           output int n, output int busy_n, output int done_n);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    n      = 1;
    busy_n = sel ? int'(busy_b) : int'(busy_a);
    done_n = 0;
    while (!(sel ? done_b : done_a) && n < budget) begin
      if (n == mid_start) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      n++;
      busy_n += sel ? int'(busy_b) : int'(busy_a);
    end
    done_n = sel ? int'(done_b) : int'(done_a);
  endtask

  int n, busy_n, done_n, k, seen;

  initial begin
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    mode_a = 0; mode_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", 32'(x_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_onset", 32'(onset_a), 0);
    chk("rst_fmv", 32'(fmv_a), 0);
    chk("rst_sig", 32'(sig_a), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy_a), 0);

    // all-zero function, SETTLE=0
    run_sweep(1'b0, 400, 0, n, busy_n, done_n);
    chk("t1_done_cycle", 32'(n), 257);
    chk("t1_busy_cycles", 32'(busy_n), 256);
    chk("t1_done", 32'(done_n), 1);
    chk("t1_onset", 32'(onset_a), 0);
    chk("t1_mism", 32'(mism_a), 0);
    chk("t1_fmv", 32'(fmv_a), 0);
    chk("t1_x_wrap", 32'(x_a), 0);
    chk("t1_sig", 32'(sig_a), 32'(misr_exp(0)));
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(done_a), 0);
    chk("t1_idle_busy", 32'(busy_a), 0);

    // y0 = x[0], golden 0
    mode_a = 1;
    run_sweep(1'b0, 400, 0, n, busy_n, done_n);
    chk("t2_onset", 32'(onset_a), 128);
    chk("t2_mism", 32'(mism_a), 128);
    chk("t2_fm", 32'(fm_a), 1);
    chk("t2_fmv", 32'(fmv_a), 1);
    chk("t2_sig", 32'(sig_a), 32'(misr_exp(1)));
    repeat (5) @(posedge clk);
    #1;
    chk("t2_hold_onset", 32'(onset_a), 128);
    chk("t2_hold_fm", 32'(fm_a), 1);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    chk("idle_abort_busy", 32'(busy_a), 0);
    chk("idle_abort_mism", 32'(mism_a), 128);

    // SETTLE=3, y0=1, golden inverted
    mode_b = 2;
    run_sweep(1'b1, 1200, 0, n, busy_n, done_n);
    chk("t3_busy_cycles", 32'(busy_n), 1024);
    chk("t3_done_cycle", 32'(n), 1025);
    chk("t3_onset", 32'(onset_b), 256);
    chk("t3_mism", 32'(mism_b), 256);
    chk("t3_fm", 32'(fm_b), 0);
    chk("t3_fmv", 32'(fmv_b), 1);
    chk("t3_sig", 32'(sig_b), 32'(misr_exp(2)));

    // abort while x=10
    mode_a = 3;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    k = 0;
    while (x_a != 8'd10 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t4_reach_x10", 32'(x_a), 10);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    chk("t4_busy", 32'(busy_a), 0);
    chk("t4_done", 32'(done_a), 0);
    chk("t4_onset", 32'(onset_a), 10);
    chk("t4_mism", 32'(mism_a), 0);
    chk("t4_fmv_cleared", 32'(fmv_a), 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      seen += int'(done_a);
    end
    chk("t4_no_done", 32'(seen), 0);
    chk("t4_x_hold", 32'(x_a), 10);

    // start mid-sweep and on the done cycle must be ignored
    mode_a = 1;
    run_sweep(1'b0, 400, 100, n, busy_n, done_n);
    chk("t5_done_cycle", 32'(n), 257);
    chk("t5_done", 32'(done_n), 1);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("t5_no_restart", 32'(busy_a), 0);
    seen = int'(done_a);
    repeat (3) begin
      @(posedge clk); #1;
      seen += int'(done_a) + int'(busy_a);
    end
    chk("t5_single_done", 32'(seen), 0);
    chk("t5_onset", 32'(onset_a), 128);
    chk("t5_mism", 32'(mism_a), 128);

    // asynchronous reset mid-sweep
    mode_a = 3;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("t6_pre_onset", 32'(onset_a), 50);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_x", 32'(x_a), 0);
    chk("t6_busy", 32'(busy_a), 0);
    chk("t6_onset", 32'(onset_a), 0);
    chk("t6_fm", 32'(fm_a), 0);
    #2;
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      seen += int'(done_a) + int'(busy_a);
    end
    chk("t6_quiet", 32'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pla_sweep_ctrl.md
PLA_SWEEP_CTRL -- requirements
Module: pla_sweep_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE, default 0, meaning the number of extra wait cycles per vector before sampling (legal range 0..15).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL provide port start, input, 1, sweep request, sampled only in IDLE.
REQ-005 SHALL provide port abort, input, 1, terminates a running sweep.
REQ-006 SHALL provide port y0, input, 1, output of the combinational function under test.
REQ-007 SHALL provide port exp_y, input, 1, golden value for the current vector, valid alongside y0.
REQ-008 SHALL provide port x, output, 8, registered vector driving function inputs x0..x7 (x[0]=x0).
REQ-009 SHALL provide port busy, output, 1, high in SWEEP.
REQ-010 SHALL provide port done, output, 1, one-cycle pulse on sweep completion.
REQ-011 SHALL provide port onset_cnt, output, 9, count of vectors with y0=1 (0..256).
REQ-012 SHALL provide port mism_cnt, output, 9, count of vectors with y0!=exp_y.
REQ-013 SHALL provide port first_mism, output, 8, x value of the first mismatch.
REQ-014 SHALL provide port first_mism_vld, output, 1, first_mism holds a valid value.
REQ-015 SHALL provide port sig, output, 16, response signature.

Function
REQ-016 SHALL implement states IDLE, SWEEP and DONE.
REQ-017 SHALL, in IDLE with start=1, enter SWEEP next cycle with x=0, clear the counters, clear first_mism_vld and first_mism, and seed sig.
REQ-018 SHALL hold each vector for SETTLE+1 cycles, using a 4-bit settle counter, and sample y0/exp_y at the rising edge ending the last cycle.
REQ-019 SHALL, on each sample, increment onset_cnt if y0=1 and mism_cnt if y0!=exp_y.
REQ-020 SHALL, on a sampled mismatch with first_mism_vld=0, load first_mism with x and set first_mism_vld.
REQ-021 SHALL increment x after each sample; after sampling x=255, go to DONE with x wrapped to 0.
REQ-022 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-023 SHALL make a full sweep take 256*(SETTLE+1) cycles in SWEEP, with done high in the following cycle.
REQ-024 SHALL ignore start outside IDLE, including start coincident with done.
REQ-025 SHALL, on abort in SWEEP, go to IDLE next cycle without a sample that edge and without done, holding partial results; abort has priority over sampling.
REQ-026 SHALL ignore abort in IDLE and DONE.
REQ-027 SHALL hold all results stable in IDLE until the next accepted start.
REQ-028 SHALL drive busy=1 only in SWEEP, combinationally from state.

Reset
REQ-029 SHALL, on rst, asynchronously force IDLE, x=0, busy=0, done=0, onset_cnt=0, mism_cnt=0, first_mism=0, first_mism_vld=0, sig=16'h0000.
REQ-030 SHALL, on rst mid-sweep, discard all partial results with no done pulse.

Configuration
REQ-031 SHALL use the macro PLA_SWEEP_MISR_EN to control the signature.
REQ-032 SHALL, when PLA_SWEEP_MISR_EN is defined, seed sig=16'hFFFF at start and, on each sample, set sig to {sig[14:0],0} XOR (sig[15]^y0 ? 16'h1021 : 0).
REQ-033 SHALL, when PLA_SWEEP_MISR_EN is undefined, keep the sig port and tie it to 16'h0000, with no MISR logic.

Verification
REQ-034 SHALL cover: SETTLE=0, y0=0, exp_y=0, start -> done exactly 257 cycles after the start edge, onset_cnt=0, mism_cnt=0, first_mism_vld=0.
REQ-035 SHALL cover: y0=x[0], exp_y=0 -> onset_cnt=128, mism_cnt=128, first_mism=1, first_mism_vld=1.
REQ-036 SHALL cover: SETTLE=3, y0=1, exp_y=~y0 -> busy for 1024 cycles, onset_cnt=256, mism_cnt=256, first_mism=0.
REQ-037 SHALL cover: abort while x=10 with y0=1 -> IDLE next cycle, no done, onset_cnt=10, x holds 10.
REQ-038 SHALL cover: start pulsed mid-sweep and on the done cycle -> no restart, counts unchanged, one done pulse.
REQ-039 SHALL cover: rst asserted mid-sweep -> all outputs 0 immediately, without a clock edge.
